bcd_mod_counter: RTL and testbench

Parametrised two-digit BCD modulo counter: the generic successor of the fixed 0–59 seconds stage, used as seconds, minutes and hours (24 h or 1–12 h) digits of the clock datapath. It counts on a single-cycle tick strobe in the system clock domain instead of a gated clock. It provides a glitch-free adjust mode with increment/decrement buttons, a parallel BCD load, and a one-cycle carry pulse for chaining the next stage.

---
 rtl/clock_pkg.sv | 49 ++++
 rtl/rise_detect.sv | 21 ++
 rtl/bcd_mod_counter.sv | 104 ++++++++++
 tb/tb_bcd_mod_counter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types, stage moduli and BCD step helpers for the clock datapath.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd2_t;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HR24_MOD = 24;
  localparam int HR12_MOD = 12;
  localparam int HR12_MIN = 1;

  // Single BCD step without range wrap; callers handle MIN/TOP wrap.
  function automatic bcd2_t bcd2_inc(bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd2_t bcd2_dec(bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == 4'd0) begin
      r.ones = 4'd9;
      r.tens = v.tens - 4'd1;
    end else begin
      r.ones = v.ones - 4'd1;
    end
    return r;
  endfunction

  function automatic bcd2_t to_bcd2(int v);
    bcd2_t r;
    r.tens = bcd_digit_t'(v / 10);
    r.ones = bcd_digit_t'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; history resets high so a level held
// through reset or a mode change is not seen as a fresh press.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic hist_q;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge clk) begin
    if (rst) hist_q <= 1'b1;
    else     hist_q <= level_i;
  end

  assign rise_o = level_i & ~hist_q;

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter stage (MIN_VAL..MIN_VAL+MOD-1) with tick
// counting, button adjust, validated parallel load and a chaining carry.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MOD     = 60,
  parameter int MIN_VAL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       adj_mode,
  input  logic       adj_inc,
  input  logic       adj_dec,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry_out,
  output logic       at_top,
  output logic       load_err
);

  localparam int    TOP     = MIN_VAL + MOD - 1;
  localparam bcd2_t MIN_BCD = to_bcd2(MIN_VAL);
  localparam bcd2_t TOP_BCD = to_bcd2(TOP);

  if (MOD < 2 || TOP > 99 || MIN_VAL < 0) begin : g_param_check
    $fatal(1, "bcd_mod_counter: MOD must be >= 2 and MIN_VAL+MOD-1 <= 99");
  end

  bcd2_t count_q, count_d;
  logic  carry_q, carry_d;
  logic  err_q, err_d;
  logic  inc_rise, dec_rise;
  bcd2_t load_bcd;
  logic  load_ok;
  logic  at_min;

  rise_detect u_inc_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i (adj_inc),
    .rise_o  (inc_rise)
  );

  rise_detect u_dec_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i (adj_dec),
    .rise_o  (dec_rise)
  );

  // With both digits <= 9, packed BCD orders the same as the decimal value.
  assign load_bcd = bcd2_t'(load_val);
  assign load_ok  = (load_bcd.tens <= 4'd9) && (load_bcd.ones <= 4'd9) &&
                    (load_bcd >= MIN_BCD) && (load_bcd <= TOP_BCD);

  assign at_top = (count_q == TOP_BCD);
  assign at_min = (count_q == MIN_BCD);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (load_ok) count_d = load_bcd;
      else         err_d   = 1'b1;
    end else if (adj_mode) begin
      if (inc_rise && !dec_rise) begin
        count_d = at_top ? MIN_BCD : bcd2_inc(count_q);
      end else if (dec_rise && !inc_rise) begin
        count_d = at_min ? TOP_BCD : bcd2_dec(count_q);
      end
    end else if (tick_in) begin
      if (at_top) begin
        count_d = MIN_BCD;
        carry_d = 1'b1;
      end else begin
        count_d = bcd2_inc(count_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= MIN_BCD;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign ones      = count_q.ones;
  assign tens      = count_q.tens;
  assign carry_out = carry_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: seconds, chained minutes, 12 h and 24 h stages
// on shared controls, checked against a decimal reference model.
module tb_bcd_mod_counter;
  import clock_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick_in, adj_mode, adj_inc, adj_dec, load;
  logic [7:0] load_val;

  logic [3:0] s_ones, s_tens, m_ones, m_tens, h12_ones, h12_tens, h24_ones, h24_tens;
  logic       s_carry, s_top, s_err, m_carry, m_top, m_err;
  logic       h12_carry, h12_top, h12_err, h24_carry, h24_top, h24_err;

  bcd_mod_counter #(.MOD(SEC_MOD), .MIN_VAL(0)) u_sec (
    .clk(clk), .rst(rst), .tick_in(tick_in), .adj_mode(adj_mode),
    .adj_inc(adj_inc), .adj_dec(adj_dec), .load(load), .load_val(load_val),
    .ones(s_ones), .tens(s_tens), .carry_out(s_carry), .at_top(s_top),
    .load_err(s_err));

  bcd_mod_counter #(.MOD(MIN_MOD), .MIN_VAL(0)) u_min (
    .clk(clk), .rst(rst), .tick_in(s_carry), .adj_mode(adj_mode),
    .adj_inc(adj_inc), .adj_dec(adj_dec), .load(load), .load_val(load_val),
    .ones(m_ones), .tens(m_tens), .carry_out(m_carry), .at_top(m_top),
    .load_err(m_err));

  bcd_mod_counter #(.MOD(HR12_MOD), .MIN_VAL(HR12_MIN)) u_h12 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .adj_mode(adj_mode),
    .adj_inc(adj_inc), .adj_dec(adj_dec), .load(load), .load_val(load_val),
    .ones(h12_ones), .tens(h12_tens), .carry_out(h12_carry), .at_top(h12_top),
    .load_err(h12_err));

  bcd_mod_counter #(.MOD(HR24_MOD), .MIN_VAL(0)) u_h24 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .adj_mode(adj_mode),
    .adj_inc(adj_inc), .adj_dec(adj_dec), .load(load), .load_val(load_val),
    .ones(h24_ones), .tens(h24_tens), .carry_out(h24_carry), .at_top(h24_top),
    .load_err(h24_err));

  typedef struct {
    logic       rst, tick, adj, inc, dec, ld;
    logic [7:0] val;
  } stim_t;

  typedef struct packed {
    logic [7:0] bcd;
    logic       carry;
    logic       top;
    logic       err;
  } obs_t;

  typedef struct { stim_t s; obs_t e; } vec_t;
  typedef struct { int id; obs_t e; } sb_t;
  typedef struct { int cnt; bit carry; bit err; } mst_t;

  localparam int    MMOD[4] = '{60, 60, 12, 24};
  localparam int    MMIN[4] = '{0, 0, 1, 0};
  localparam string NM[5]   = '{"sec", "min", "h12", "h24", "sec_tab"};

  int   checks = 0;
  int   errors = 0;
  sb_t  sb[$];
  mst_t ms[4];
  bit   inc_h = 1'b1, dec_h = 1'b1;
  vec_t tab[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic stim_t st(logic r, logic t, logic a, logic i, logic d, logic l, logic [7:0] v);
    stim_t s;
    s.rst = r; s.tick = t; s.adj = a; s.inc = i; s.dec = d; s.ld = l; s.val = v;
    return s;
  endfunction

  function automatic obs_t ob(logic [7:0] b, logic c, logic t, logic e);
    obs_t o;
    o.bcd = b; o.carry = c; o.top = t; o.err = e;
    return o;
  endfunction

  // Decimal reference: count kept as an integer, converted to BCD only for comparison.
  function automatic mst_t mstep(mst_t m, int md, int mn, stim_t s, bit tick, bit ir, bit dr);
    mst_t n;
    int   top, lt, lo, v;
    top = mn + md - 1;
    n = m; n.carry = 1'b0; n.err = 1'b0;
    lt = int'(s.val[7:4]); lo = int'(s.val[3:0]); v = lt * 10 + lo;
    if (s.rst) n.cnt = mn;
    else if (s.ld) begin
      if (lt <= 9 && lo <= 9 && v >= mn && v <= top) n.cnt = v;
      else n.err = 1'b1;
    end else if (s.adj) begin
      if (ir && !dr)      n.cnt = (m.cnt == top) ? mn : m.cnt + 1;
      else if (dr && !ir) n.cnt = (m.cnt == mn) ? top : m.cnt - 1;
    end else if (tick) begin
      if (m.cnt == top) begin n.cnt = mn; n.carry = 1'b1; end
      else n.cnt = m.cnt + 1;
    end
    return n;
  endfunction

  function automatic obs_t mobs(mst_t m, int md, int mn);
    return ob({bcd_digit_t'(m.cnt / 10), bcd_digit_t'(m.cnt % 10)}, m.carry,
              m.cnt == mn + md - 1, m.err);
  endfunction

  function automatic obs_t dut_obs(int id);
    case (id)
      1:       return ob({m_tens, m_ones}, m_carry, m_top, m_err);
      2:       return ob({h12_tens, h12_ones}, h12_carry, h12_top, h12_err);
      3:       return ob({h24_tens, h24_ones}, h24_carry, h24_top, h24_err);
      default: return ob({s_tens, s_ones}, s_carry, s_top, s_err);
    endcase
  endfunction

  // One clock: drive, push model (and optional table) expectations, then
  // pop and compare 1 time unit after the edge.
  task automatic cycle(input stim_t s, input bit has_tab, input obs_t te, input string tag);
    mst_t nx[4];
    bit   ir, dr, tk;
    sb_t  item;
    rst = s.rst; tick_in = s.tick; adj_mode = s.adj; adj_inc = s.inc;
    adj_dec = s.dec; load = s.ld; load_val = s.val;
    ir = s.inc & ~inc_h;
    dr = s.dec & ~dec_h;
    for (int i = 0; i < 4; i++) begin
      tk = (i == 1) ? ms[0].carry : s.tick;
      nx[i] = mstep(ms[i], MMOD[i], MMIN[i], s, tk, ir, dr);
    end
    ms = nx;
    inc_h = s.rst ? 1'b1 : s.inc;
    dec_h = s.rst ? 1'b1 : s.dec;
    for (int i = 0; i < 4; i++) sb.push_back('{i, mobs(ms[i], MMOD[i], MMIN[i])});
    if (has_tab) sb.push_back('{4, te});
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      item = sb.pop_front();
      check($sformatf("%s/%s", tag, NM[item.id]), 32'(dut_obs(item.id)), 32'(item.e));
    end
  endtask

  task automatic run(input stim_t s, input string tag);
    cycle(s, 1'b0, ob(8'h00, 1'b0, 1'b0, 1'b0), tag);
  endtask

  int carries, tops, seen;

  initial begin
    rst = 1'b1; tick_in = 1'b0; adj_mode = 1'b0; adj_inc = 1'b0;
    adj_dec = 1'b0; load = 1'b0; load_val = 8'h00;
    for (int i = 0; i < 4; i++) ms[i] = '{MMIN[i], 1'b0, 1'b0};

    tab[0]  = '{st(1,0,0,0,0,0,8'h00), ob(8'h00,0,0,0)};
    tab[1]  = '{st(0,0,0,0,0,1,8'h45), ob(8'h45,0,0,0)};
    tab[2]  = '{st(0,0,0,0,0,1,8'h4A), ob(8'h45,0,0,1)};
    tab[3]  = '{st(0,0,0,0,0,0,8'h00), ob(8'h45,0,0,0)};
    tab[4]  = '{st(0,0,0,0,0,1,8'h60), ob(8'h45,0,0,1)};
    tab[5]  = '{st(0,1,0,0,0,1,8'h58), ob(8'h58,0,0,0)};
    tab[6]  = '{st(0,1,0,0,0,0,8'h00), ob(8'h59,0,1,0)};
    tab[7]  = '{st(0,1,0,0,0,0,8'h00), ob(8'h00,1,0,0)};
    tab[8]  = '{st(0,1,0,0,0,0,8'h00), ob(8'h01,0,0,0)};
    tab[9]  = '{st(0,1,1,0,0,0,8'h00), ob(8'h01,0,0,0)};
    tab[10] = '{st(0,0,1,1,0,0,8'h00), ob(8'h02,0,0,0)};
    tab[11] = '{st(0,0,1,1,0,0,8'h00), ob(8'h02,0,0,0)};
    tab[12] = '{st(0,0,1,0,1,0,8'h00), ob(8'h01,0,0,0)};
    tab[13] = '{st(0,0,1,0,0,0,8'h00), ob(8'h01,0,0,0)};
    tab[14] = '{st(0,0,1,1,1,0,8'h00), ob(8'h01,0,0,0)};
    tab[15] = '{st(0,0,1,0,0,0,8'h00), ob(8'h01,0,0,0)};
    tab[16] = '{st(0,0,1,0,1,0,8'h00), ob(8'h00,0,0,0)};
    tab[17] = '{st(0,0,1,0,0,0,8'h00), ob(8'h00,0,0,0)};
    tab[18] = '{st(0,0,1,0,1,0,8'h00), ob(8'h59,0,1,0)};
    tab[19] = '{st(0,0,0,0,0,0,8'h00), ob(8'h59,0,1,0)};

    @(negedge clk);
    for (int i = 0; i < 20; i++) cycle(tab[i].s, 1'b1, tab[i].e, $sformatf("vec%0d", i));

    // Seconds wrap over 60 back-to-back ticks; 12 h stage wraps alongside.
    run(st(1,0,0,0,0,0,8'h00), "wrap_rst");
    check("h12_reset", 32'({h12_tens, h12_ones, h12_carry}), 32'({8'h01, 1'b0}));
    check("sec_reset", 32'({s_tens, s_ones, s_carry, s_err}), 32'({8'h00, 2'b00}));
    carries = 0; tops = 0;
    for (int k = 1; k <= 60; k++) begin
      run(st(0,1,0,0,0,0,8'h00), $sformatf("wrap%0d", k));
      carries += int'(s_carry);
      tops    += int'(s_top);
      if (k == 11) check("h12_at_12", 32'({h12_tens, h12_ones, h12_top}), 32'({8'h12, 1'b1}));
      if (k == 12) check("h12_wrap", 32'({h12_tens, h12_ones, h12_carry}), 32'({8'h01, 1'b1}));
    end
    check("sec_wrap_value", 32'({s_tens, s_ones}), 32'h00);
    check("sec_carry_count", 32'(carries), 32'd1);
    check("sec_top_count", 32'(tops), 32'd1);
    run(st(0,0,1,0,0,0,8'h00), "h12_adj");
    run(st(0,0,1,0,1,0,8'h00), "h12_dec");
    check("h12_dec_wrap", 32'({h12_tens, h12_ones, h12_carry}), 32'({8'h12, 1'b0}));
    run(st(0,0,1,0,0,0,8'h00), "h12_rel");

    // 24 h adjust: held inc fires once, ticks ignored, no carry.
    run(st(0,0,0,0,0,1,8'h23), "h24_load");
    run(st(0,0,1,0,0,0,8'h00), "h24_adj");
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      run(st(0,1,1,1,0,0,8'h00), $sformatf("h24_hold%0d", k));
      seen += int'(h24_carry);
    end
    check("h24_hold_value", 32'({h24_tens, h24_ones}), 32'h00);
    check("h24_no_carry", 32'(seen), 32'd0);
    run(st(0,0,1,0,0,0,8'h00), "h24_rel");

    // Button held through reset and into adjust mode must not fire.
    run(st(1,0,0,1,0,0,8'h00), "held_rst0");
    run(st(1,0,0,1,0,0,8'h00), "held_rst1");
    run(st(0,0,0,1,0,0,8'h00), "held_run");
    for (int k = 0; k < 3; k++) run(st(0,0,1,1,0,0,8'h00), $sformatf("held_adj%0d", k));
    check("held_no_inc", 32'({s_tens, s_ones}), 32'h00);
    run(st(0,0,1,0,0,0,8'h00), "held_release");
    run(st(0,0,1,1,0,0,8'h00), "held_press");
    check("held_repress", 32'({s_tens, s_ones}), 32'h01);
    run(st(0,0,0,0,0,0,8'h00), "held_exit");

    // Chain 59:59 -> 00:00, minutes carry one cycle after seconds carry.
    run(st(0,0,0,0,0,1,8'h59), "chain_load");
    run(st(0,1,0,0,0,0,8'h00), "chain_tick");
    check("chain_sec", 32'({s_tens, s_ones, s_carry, m_tens, m_ones, m_carry}),
          32'({8'h00, 1'b1, 8'h59, 1'b0}));
    run(st(0,0,0,0,0,0,8'h00), "chain_skew");
    check("chain_min", 32'({s_tens, s_ones, s_carry, m_tens, m_ones, m_carry}),
          32'({8'h00, 1'b0, 8'h00, 1'b1}));

    // Reset in a wrap cycle wins with no carry.
    run(st(0,0,0,0,0,1,8'h59), "rstwrap_load");
    run(st(1,1,0,0,0,0,8'h00), "rstwrap");
    check("rst_mid_wrap", 32'({s_tens, s_ones, s_carry}), 32'({8'h00, 1'b0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
